// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, and a small
// instruction FIFO toward decode. Optional bubble counter: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_bubble_count
`endif
);

    localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        req_pc_q;
    logic               drop_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [31:0]        inst_mem_q [FIFO_DEPTH];
    logic [31:0]        pc_mem_q   [FIFO_DEPTH];

    logic [31:0] target;
    logic        push;
    logic        pop;
    logic [1:0]  unused_redirect_lsb;

    assign target              = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = i_redirect_pc[1:0];

    // Valid/ready: a transfer happens on an edge where both valid and ready
    // are high. A response is only taken in WAIT, and a redirect kills it.
    assign push = (state_q == S_WAIT) && i_imem_rvalid && !drop_q && !i_redirect;
    assign pop  = o_inst_valid && i_inst_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_ADDR;
            req_pc_q <= RESET_ADDR;
            drop_q   <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (i_redirect) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_redirect) begin
                        pc_q <= target;
                    end else if (count_q < DEPTH_C) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_redirect) begin
                        pc_q    <= target;
                        state_q <= S_IDLE;
                    end else if (i_imem_ready) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (i_redirect) pc_q <= target;
                        state_q <= (!i_redirect && (count_d < DEPTH_C)) ? S_REQ : S_IDLE;
                    end else if (i_redirect) begin
                        // Response still owed for the old address; discard it on arrival.
                        drop_q <= 1'b1;
                        pc_q   <= target;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && i_rst_n) begin
            inst_mem_q[wr_ptr_q] <= i_imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign o_imem_req   = (state_q == S_REQ);
    assign o_imem_addr  = pc_q;
    assign o_inst_valid = (count_q != '0);
    assign o_inst       = o_inst_valid ? inst_mem_q[rd_ptr_q] : NOP;
    assign o_inst_pc    = o_inst_valid ? pc_mem_q[rd_ptr_q] : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bubble_q <= '0;
        end else if (i_inst_ready && !o_inst_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign o_bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirects,
// PC wraparound (second instance) and, when enabled, the bubble counter.
module tb_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, imem_rvalid, redirect, inst_valid, inst_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
    logic        w_req, w_ready, w_rvalid, w_valid;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_count, w_bubble;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ready(imem_ready),
        .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
        .i_inst_ready(inst_ready)
`ifdef FETCH_PERF_CNT_EN
        , .o_bubble_count(bubble_count)
`endif
    );

    fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ready(w_ready),
        .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
        .i_redirect(1'b0), .i_redirect_pc(32'h0),
        .o_inst_valid(w_valid), .o_inst(w_inst), .o_inst_pc(w_pc),
        .i_inst_ready(1'b0)
`ifdef FETCH_PERF_CNT_EN
        , .o_bubble_count(w_bubble)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; inst_ready = 0;
        w_ready = 0; w_rvalid = 0; w_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        step();
    endtask

    // Accept one request at addr, return addr^K next cycle, then check the FIFO head.
    task automatic serve(input logic [31:0] addr, input logic [31:0] head_pc);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++; $display("FAIL serve_req req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, addr);
        end
        imem_ready = 1; step();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = addr ^ K; step();
        imem_rvalid = 0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== head_pc || inst !== (head_pc ^ K)) begin
            errors++; $display("FAIL serve_head valid=%b pc=%h inst=%h expected 1 %h %h", inst_valid, inst_pc, inst, head_pc, head_pc ^ K);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (3) step();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 || inst !== NOP || inst_pc !== 32'h0) begin
            errors++; $display("FAIL reset_state req=%b valid=%b addr=%h inst=%h pc=%h expected 0 0 0 %h 0", imem_req, inst_valid, imem_addr, inst, inst_pc, NOP);
        end
        rst_n = 1; step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_release req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        inst_ready = 1;
        for (int i = 0; i < 4; i++) serve(32'(i * 4), 32'(i * 4));
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL stream_next req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 0;
        serve(32'h0, 32'h0);
        serve(32'h4, 32'h0);
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_full_req req=%b expected 0", imem_req);
        end
        inst_ready = 1; step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== (32'h4 ^ K) || imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_pop1 valid=%b pc=%h inst=%h req=%b expected 1 4 %h 0", inst_valid, inst_pc, inst, imem_req, 32'h4 ^ K);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL bp_resume valid=%b req=%b addr=%h expected 0 1 8", inst_valid, imem_req, imem_addr);
        end
        inst_ready = 0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        inst_ready = 1;
        imem_ready = 1; step();
        imem_ready = 0; redirect = 1; redirect_pc = 32'h100; step();
        redirect = 0; step(); step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_wait_hold req=%b addr=%h expected 0 100", imem_req, imem_addr);
        end
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
        imem_rvalid = 0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_stale valid=%b req=%b addr=%h expected 0 1 100", inst_valid, imem_req, imem_addr);
        end
        serve(32'h100, 32'h100);
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        inst_ready = 0;
        serve(32'h0, 32'h0);
        imem_ready = 1; step();
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h4 ^ K;
        redirect = 1; redirect_pc = 32'h103; inst_ready = 1; step();
        clear_inputs();
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_flush valid=%b inst=%h pc=%h req=%b expected 0 %h 0 0", inst_valid, inst, inst_pc, imem_req, NOP);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_refetch req=%b addr=%h expected 1 100", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first req=%b addr=%h expected 1 fffffffc", w_req, w_addr);
        end
        w_ready = 1; step();
        w_ready = 0; w_rvalid = 1; w_rdata = 32'h1234_5678; step();
        w_rvalid = 0;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'h0 || w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_inst !== 32'h1234_5678) begin
            errors++; $display("FAIL wrap_next req=%b addr=%h valid=%b pc=%h inst=%h expected 1 0 1 fffffffc 12345678", w_req, w_addr, w_valid, w_pc, w_inst);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_bubble();
        do_reset();
        checks++;
        if (bubble_count !== 32'd0) begin
            errors++; $display("FAIL bubble_reset got=%0d expected 0", bubble_count);
        end
        inst_ready = 1;
        repeat (5) step();
        inst_ready = 0;
        checks++;
        if (bubble_count !== 32'd5) begin
            errors++; $display("FAIL bubble_five got=%0d expected 5", bubble_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_bubble();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that directly feeds the decode stage, which consumes the opcode field of o_inst.
- Holds the PC and issues word requests to instruction memory over a request/response handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight instructions.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- o_imem_req  output  1  fetch request valid.
- o_imem_addr  output  32  fetch word address; bits [1:0] always 0.
- i_imem_ready  input  1  memory accepts request; handshake = o_imem_req & i_imem_ready.
- i_imem_rvalid  input  1  response valid; in order, at most one per accepted request.
- i_imem_rdata  input  32  instruction word.
- i_redirect  input  1  branch/jump taken; flush and refetch.
- i_redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
- o_inst_valid  output  1  FIFO head valid.
- o_inst  output  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty.
- o_inst_pc  output  32  PC of FIFO head; 0 when empty.
- i_inst_ready  input  1  decode accepts head; pop = o_inst_valid & i_inst_ready.

Behaviour:
Reset (i_rst_n low at edge):
- state=IDLE, pc=RESET_ADDR, FIFO empty, drop=0.
- Outputs: o_imem_req=0, o_imem_addr=RESET_ADDR, o_inst_valid=0, o_inst=NOP, o_inst_pc=0.
- Reset mid-transaction abandons any outstanding request. A late i_imem_rvalid is ignored: drop is not meaningful after reset, and rvalid is only accepted in WAIT.

FSM; o_imem_req = (state==REQ), o_imem_addr = pc:
- IDLE: if i_redirect, pc<=target and stay. Else if count < FIFO_DEPTH, go to REQ.
- REQ: i_redirect has priority; go to IDLE with pc<=target, withdrawing the request (the only legal request drop). Else on i_imem_ready, go to WAIT with pc<=pc+4.
- WAIT, on i_imem_rvalid:
  - Push {pc_of_request, rdata} unless drop or i_redirect is set; then clear drop.
  - Next state is REQ if post-update count < FIFO_DEPTH and no i_redirect, else IDLE.
  - A redirect in the same cycle sets pc<=target; drop stays 0 because the response is consumed.
- WAIT without rvalid: i_redirect sets drop=1 and pc<=target; stay in WAIT.

Rules:
- At most one outstanding request. Space is reserved before issue, so a push never hits a full FIFO.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- The PC of the in-flight request is held in a register separate from pc.
- i_redirect flushes the FIFO (count<=0) on the same edge. A simultaneous pop and/or push is discarded, and o_inst_valid=0 the next cycle.
- Push and pop in the same cycle: count unchanged, order preserved.
- Latency, no stalls:
  - Request accepted at edge N, rvalid at N+1, push at N+1, o_inst_valid visible after N+1.
  - Next request issues the cycle after the response.
  - Steady throughput is 1 instruction per 2 cycles.
- First request is visible in the first cycle after the first clock with i_rst_n high.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output o_bubble_count [31:0], reset to 0. It increments (saturating at 32'hFFFF_FFFF) each cycle i_inst_ready=1 and o_inst_valid=0, excluding reset cycles.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Hold i_rst_n=0 three cycles -> o_imem_req=0, o_inst_valid=0, o_imem_addr=0. Release -> o_imem_req=1, addr=0 one cycle later.
- Streaming: ready=1, rvalid one cycle after accept, data=pc^32'hA5A5_0000, i_inst_ready=1 -> decode receives pc 0,4,8,12 with matching data, one every 2 cycles.
- Backpressure: i_inst_ready=0 -> after pc 0,4 buffered, o_imem_req stays 0. Raise ready -> pops pc 0 then 4, next request addr=8.
- Redirect to 0x100 while WAIT, rvalid 3 cycles later -> stale word discarded, next o_inst_valid has pc=0x100.
- Redirect to 0x103 same cycle as rvalid and a pop with FIFO holding 1 entry -> next cycle o_inst_valid=0, o_inst=NOP, next request addr=0x100.
- RESET_ADDR=32'hFFFF_FFFC -> requests at 0xFFFF_FFFC then 0x0. With FETCH_PERF_CNT_EN, 5 empty ready cycles -> o_bubble_count=5.
